// File: rtl/eight_bit_adder.sv
// 8-bit ripple-carry adder with registered sum, carry-out and signed overflow.
// The ripple chain is built from eight explicit 1-bit full adder cells.

module eight_bit_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

module eight_bit_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       in_valid,
  output logic [7:0] o,
  output logic       cout,
  output logic       over_flow,
  output logic       out_valid
);

  logic [8:0] carry;
  logic [7:0] sum;
  logic       ovf;

  logic [7:0] o_d, o_q;
  logic       cout_d, cout_q;
  logic       over_flow_d, over_flow_q;
  logic       out_valid_d, out_valid_q;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    eight_bit_adder_fa u_fa (
      .a_i (a[i]),
      .b_i (b[i]),
      .c_i (carry[i]),
      .s_o (sum[i]),
      .c_o (carry[i+1])
    );
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf = carry[7] ^ carry[8];

  always_comb begin
    o_d         = o_q;
    cout_d      = cout_q;
    over_flow_d = over_flow_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      o_d         = sum;
      cout_d      = carry[8];
      over_flow_d = ovf;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q         <= 8'h00;
      cout_q      <= 1'b0;
      over_flow_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      o_q         <= o_d;
      cout_q      <= cout_d;
      over_flow_q <= over_flow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o         = o_q;
  assign cout      = cout_q;
  assign over_flow = over_flow_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_eight_bit_adder.sv
// Scoreboard bench for eight_bit_adder: expected results are queued when
// operands are driven and compared when out_valid is seen.

module tb_eight_bit_adder;

  typedef struct packed {
    logic [7:0] o;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       in_valid;
  logic [7:0] o;
  logic       cout;
  logic       over_flow;
  logic       out_valid;

  int   total;
  int   bad;
  exp_t sb[$];
  exp_t held;

  eight_bit_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .o         (o),
    .cout      (cout),
    .over_flow (over_flow),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t       r;
    logic [8:0] s;
    s      = {1'b0, x} + {1'b0, y};
    r.o    = s[7:0];
    r.cout = s[8];
    r.ovf  = (x[7] == y[7]) && (s[7] != x[7]);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Drive one cycle of operands at a falling edge; queue the expected result.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic v);
    a        = x;
    b        = y;
    in_valid = v;
    if (v) sb.push_back(model(x, y));
    @(negedge clk);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_o"},         32'(o),         32'h0);
    checkOutput({tag, "_cout"},      32'(cout),      32'h0);
    checkOutput({tag, "_ovf"},       32'(over_flow), 32'h0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'h0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_valid", 32'(out_valid), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sum",  32'(o),         32'(e.o));
        checkOutput("cout", 32'(cout),      32'(e.cout));
        checkOutput("ovf",  32'(over_flow), 32'(e.ovf));
        held = e;
      end
    end
  end

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    in_valid = 1'b0;
    held     = '0;
    #1;
    checkZero("reset_init");

    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h80, 8'h80, 1'b1);
    applyStimulus(8'h00, 8'h00, 1'b0);

    // Reset asserted between edges must clear outputs without a clock.
    #2 rst_n = 1'b0;
    #1 checkZero("reset_async");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'h00, 8'h00, 1'b1);
    applyStimulus(8'h01, 8'h02, 1'b1);
    applyStimulus(8'h04, 8'h06, 1'b1);
    applyStimulus(8'h40, 8'h60, 1'b1);
    applyStimulus(8'h52, 8'h68, 1'b1);
    applyStimulus(8'hD2, 8'hE8, 1'b1);
    applyStimulus(8'h98, 8'hA4, 1'b1);

    applyStimulus(8'hFF, 8'h01, 1'b0);
    checkOutput("hold_valid", 32'(out_valid), 32'h0);
    checkOutput("hold_o",     32'(o),         32'(held.o));
    checkOutput("hold_cout",  32'(cout),      32'(held.cout));
    checkOutput("hold_ovf",   32'(over_flow), 32'(held.ovf));
    applyStimulus(8'hFF, 8'h01, 1'b0);
    checkOutput("hold2_o",    32'(o),         32'h3C);
    checkOutput("hold2_valid", 32'(out_valid), 32'h0);

    applyStimulus(8'hFF, 8'h01, 1'b1);
    applyStimulus(8'h00, 8'h00, 1'b0);

    // Abort: valid operands present, reset lands before the capture edge.
    a        = 8'hFF;
    b        = 8'h01;
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 checkZero("abort");
    @(negedge clk);
    in_valid = 1'b0;
    checkZero("abort_held");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_no_result", 32'(out_valid), 32'h0);
    checkOutput("abort_o",         32'(o),         32'h0);

    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        applyStimulus(8'(i), 8'(j), 1'b1);
      end
    end
    applyStimulus(8'h00, 8'h00, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("drain", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eight_bit_adder.md
Name: eight_bit_adder

Overview:
8-bit two's-complement/unsigned adder with registered outputs, used as a datapath arithmetic primitive. It computes a + b and reports the 8-bit sum, the unsigned carry-out and the signed overflow flag, captured one clock after a valid input. The internal adder is a structural ripple-carry chain of eight 1-bit full adders; the registers sit at the outputs only.

Parameters:
None. The width is fixed at 8 bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
o  output  8  registered sum bits [7:0] of a + b
cout  output  1  registered carry out of bit 7 (unsigned overflow)
over_flow  output  1  registered signed overflow flag
a  input  8  operand A, unsigned or two's complement
b  input  8  operand B, unsigned or two's complement
in_valid  input  1  operands valid this cycle
out_valid  output  1  o/cout/over_flow hold a fresh result

Behaviour:
- Clocking: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset:
  - While rst_n = 0, o = 8'h00, cout = 0, over_flow = 0 and out_valid = 0, immediately and independent of clk.
  - Release is synchronous in effect: the first capture happens on the first rising edge with rst_n = 1.
- Combinational core:
  - c0 = 0.
  - For i = 0..7: s[i] = a[i]^b[i]^c[i], and c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
  - Sum = s[7:0]; carry = c8; ovf = c7 ^ c8, equivalently (a[7]==b[7]) && (s[7]!=a[7]).
- Capture rule:
  - On a rising clk edge with in_valid = 1: o <= s, cout <= c8, over_flow <= ovf, out_valid <= 1.
  - On a rising clk edge with in_valid = 0: o, cout and over_flow hold their previous values; out_valid <= 0.
- Latency and throughput: 1 cycle. Back-to-back valid inputs give back-to-back results with no stall. There is no backpressure.
- Flag semantics:
  - cout is meaningful for unsigned interpretation; over_flow is meaningful for signed interpretation.
  - Both flags are always computed and registered together.
  - The flags are independent: any of the four combinations may occur.
- Wrap-around: the result is modulo 256. The sum is never saturated.
- Reset mid-operation: asserting rst_n low between edges clears all outputs at once and drops any pending result. No result is produced for the cycle in which reset was asserted.
- Unknown inputs: X on a or b while in_valid = 1 may propagate to the outputs. in_valid itself must never be X after reset.

Test Plan:
1. Reset and basic sums.
   - Assert rst_n = 0 mid-cycle -> o = 00, cout = 0, over_flow = 0, out_valid = 0 without waiting for a clock edge.
   - Release reset, then apply a = 00, b = 00 with in_valid = 1 -> next cycle o = 00, cout = 0, over_flow = 0, out_valid = 1.
2. Small positive sums, applied back-to-back:
   - 01 + 02 -> o = 03, cout = 0, over_flow = 0.
   - 04 + 06 -> o = 0A, cout = 0, over_flow = 0.
   - Results appear on consecutive cycles.
3. Positive signed overflow:
   - 40 + 60 -> o = A0, cout = 0, over_flow = 1.
   - 52 + 68 -> o = BA, cout = 0, over_flow = 1.
4. Negative operands:
   - D2 + E8 (-46 + -24) -> o = BA (-70), cout = 1, over_flow = 0.
   - 98 + A4 (-104 + -92) -> o = 3C, cout = 1, over_flow = 1.
5. Hold and reset abort.
   - Drop in_valid and change a/b to FF, 01 -> outputs keep their previous values, out_valid = 0.
   - Then FF + 01 with in_valid = 1 -> o = 00, cout = 1, over_flow = 0.
   - Assert rst_n low before the capture edge -> all outputs 0, and no result appears.
6. Exhaustive sweep: all 65536 (a, b) pairs with in_valid = 1 -> each result one cycle later matches the reference model:
   - {cout, o} = a + b
   - over_flow = (a[7]==b[7]) && (o[7]!=a[7])
